ds1302_burst_io: RTL

- Parametrised next-generation DS1302 3-wire controller.
- Drives CE, SCLK and bidirectional IO itself; there is no separate SPI master.
- Adds burst mode (clock burst, up to 8 bytes; RAM burst, up to 31 bytes), RAM/clock register select, configurable timing, and byte-streamed data.
- Sits between the RTC application logic and the DS1302 pins.

---
 rtl/ds1302_burst_io.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ds1302_burst_io.sv
// DS1302 3-wire controller: single-byte and burst transfers over CE/SCLK/IO.
// Write bytes are pulled with wr_req, read bytes are pushed out with rd_valid.
module ds1302_burst_io #(
  parameter int CLK_DIV   = 50,
  parameter int CE_SETUP  = 256,
  parameter int CE_HOLD   = 256,
  parameter int CE_GAP    = 256,
  parameter int MAX_BURST = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_ram,
  input  logic       cmd_burst,
  input  logic [4:0] cmd_addr,
  input  logic [4:0] cmd_len,
  input  logic [7:0] wr_data,
  output logic       wr_req,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       busy,
  output logic       ds1302_ce,
  output logic       ds1302_sclk,
  inout  wire        ds1302_io
);
  localparam int M1   = (CLK_DIV > CE_SETUP) ? CLK_DIV : CE_SETUP;
  localparam int M2   = (CE_HOLD > CE_GAP) ? CE_HOLD : CE_GAP;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CE_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CE_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_WDATA, S_RDATA, S_HOLD, S_GAP
  } state_t;

  state_t        state;
  logic          rst_gap;
  logic [CW-1:0] cnt;
  logic          phase_hi;
  logic [2:0]    bit_idx;
  logic [4:0]    bytes_left;
  logic          is_read;
  logic [7:0]    tx;
  logic [6:0]    rx;
  logic          io_oe, io_out;
  logic [4:0]    len_eff;
  logic [7:0]    cmd_byte;

  assign ds1302_io = io_oe ? io_out : 1'bz;

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == 5'd0)                  len_eff = 5'd1;
    else if (int'(cmd_len) > MAX_BURST)   len_eff = 5'(MAX_BURST);
  end

  // Wire order is bit 0 first: R/W, address, RAM/CK, then the fixed 1.
  assign cmd_byte = {1'b1, cmd_ram, (cmd_burst ? 5'd31 : cmd_addr), cmd_read};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rst_gap     <= 1'b1;
      cnt         <= '0;
      phase_hi    <= 1'b0;
      bit_idx     <= 3'd0;
      bytes_left  <= 5'd0;
      is_read     <= 1'b0;
      tx          <= 8'h00;
      rx          <= 7'h00;
      io_oe       <= 1'b1;
      io_out      <= 1'b0;
      ds1302_ce   <= 1'b0;
      ds1302_sclk <= 1'b0;
      rd_data     <= 8'h00;
      wr_req      <= 1'b0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b0;
    end else begin
      wr_req   <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rst_gap) begin
            rst_gap <= 1'b0;
            state   <= S_GAP;
            busy    <= 1'b1;
            cnt     <= '0;
          end else if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            ds1302_ce  <= 1'b1;
            is_read    <= cmd_read;
            tx         <= cmd_byte;
            bytes_left <= cmd_burst ? len_eff : 5'd1;
            cnt        <= '0;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt      <= '0;
            phase_hi <= 1'b0;
            bit_idx  <= 3'd0;
            io_out   <= tx[0];
            state    <= S_CMD;
          end else cnt <= cnt + 1'b1;
        end
        S_CMD, S_WDATA, S_RDATA: begin
          // Write byte arrives during the wr_req clk; bit 0 goes out right after it.
          if (state == S_WDATA && wr_req) begin
            tx     <= wr_data;
            io_out <= wr_data[0];
          end
          if (cnt != DIV_LAST) cnt <= cnt + 1'b1;
          else begin
            cnt         <= '0;
            phase_hi    <= !phase_hi;
            ds1302_sclk <= !phase_hi;
            if (!phase_hi) begin
              if (state == S_RDATA) begin
                rx <= {ds1302_io, rx[6:1]};
                if (bit_idx == 3'd7) begin
                  rd_data  <= {ds1302_io, rx};
                  rd_valid <= 1'b1;
                end
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx != 3'd7) begin
                if (state != S_RDATA) io_out <= tx[bit_idx + 3'd1];
              end else if (state == S_CMD) begin
                state  <= is_read ? S_RDATA : S_WDATA;
                io_oe  <= !is_read;
                wr_req <= !is_read;
              end else if (bytes_left == 5'd1) begin
                state  <= S_HOLD;
                io_oe  <= 1'b1;
                io_out <= 1'b0;
              end else begin
                bytes_left <= bytes_left - 5'd1;
                wr_req     <= (state == S_WDATA);
              end
            end
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            ds1302_ce <= 1'b0;
            done      <= 1'b1;
            state     <= S_GAP;
          end else cnt <= cnt + 1'b1;
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt       <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
